ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL expose parameter: DATA_W, 32, operand/result width (only 32 is supported).
REQ-002 SHALL have ports in this order:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  kill instruction held in stage.
- ds_valid_i  in  1  upstream (decode) has an instruction.
- es_allowin_o  out  1  stage accepts an instruction this cycle.
- ds_aluop_i  in  5  operation code (package enum).
- ds_x_i  in  32  source operand x.
- ds_y_i  in  32  source operand y.
- ds_dest_i  in  5  destination register.
- ds_we_i  in  1  register write enable.
- alu_aluop_o  out  4  opcode to the combinational ALU.
- alu_x_o  out  32  ALU operand x.
- alu_y_o  out  32  ALU operand y.
- alu_rl_i  in  32  ALU low result.
- alu_rh_i  in  32  ALU high result.
- ms_allowin_i  in  1  downstream (memory stage) accepts.
- es_valid_o  out  1  result valid to downstream.
- es_result_o  out  32  result.
- es_dest_o  out  5  destination register.
- es_we_o  out  1  write enable, gated by es_valid_o.

Function
REQ-003 SHALL hold one instruction in registers es_valid, aluop, x, y, dest, we, loaded when ds_valid_i && es_allowin_o.
REQ-004 SHALL compute es_allowin_o = !es_valid || (es_ready_go && ms_allowin_i).
REQ-005 SHALL compute es_valid_o = es_valid && es_ready_go && !flush_i.
REQ-006 SHALL clear es_valid when es_valid_o && ms_allowin_i and no new instruction is loaded the same cycle; simultaneous hand-off and load SHALL replace contents with no bubble.
REQ-007 SHALL drive alu_x_o/alu_y_o from held operands and alu_aluop_o from the held opcode for ALU ops (shift, add, sub, logic, slt, sltu, lui, mul, mulu, mulh, mulhu).
REQ-008 SHALL select es_result_o = alu_rh_i for MULH/MULHU, alu_rl_i for other ALU ops; ALU ops have es_ready_go = 1 (zero added latency).
REQ-009 SHALL execute DIV, DIVU, MOD, MODU in an internal iterative radix-2 restoring divider, not the ALU.
REQ-010 Divider FSM states IDLE, BUSY, DONE: IDLE->BUSY when a valid divide op is held; BUSY iterates one quotient bit per cycle with 6-bit counter, 32 cycles; BUSY->DONE after bit 0; DONE->IDLE on hand-off (es_valid_o && ms_allowin_i).
REQ-011 Divide latency SHALL be exactly 33 cycles from capture to es_valid_o (1 setup + 32 iterations); es_ready_go = 1 only in DONE.
REQ-012 Signed ops SHALL divide magnitudes and fix signs: quotient negative iff signs differ, remainder takes dividend sign.
REQ-013 Divide by zero SHALL yield quotient 32'hFFFF_FFFF and remainder = dividend (signed and unsigned).
REQ-014 Signed overflow (32'h8000_0000 / 32'hFFFF_FFFF) SHALL yield quotient 32'h8000_0000, remainder 0.
REQ-015 Unknown opcodes SHALL produce result 0, ready_go = 1.
REQ-016 flush_i SHALL clear es_valid next edge and return divider FSM to IDLE from any state; a ds load in the flush cycle SHALL be suppressed.
REQ-017 Downstream stall (ms_allowin_i = 0) SHALL hold all outputs stable, including divider in DONE.

Reset
REQ-018 On rst: es_valid = 0, FSM = IDLE, counter = 0, held operands/dest/we = 0; thus es_valid_o = 0, es_we_o = 0, es_result_o = 0, es_allowin_o = 1.
REQ-019 Reset mid-divide SHALL abort immediately with no result emitted.

Structure
REQ-020 Shared package SHALL hold the 5-bit aluop enum, its mapping to the 4-bit ALU code, divider state enum, and DATA_W.
REQ-021 Divider SHALL be sub-module iter_divider (start, signed flag, dividend, divisor, abort -> busy, done, quotient, remainder).

Verification
REQ-022 ADD x=5,y=7, ms_allowin=1 -> es_valid_o next cycle after capture, result 12, no stall.
REQ-023 DIV x=-7,y=2 -> es_allowin_o low 33 cycles, result -3; MOD same -> -1.
REQ-024 DIVU x=10,y=0 -> quotient 32'hFFFF_FFFF; MODU -> 10.
REQ-025 DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; back-to-back ADDs with ms_allowin=0 for 3 cycles -> outputs stable, no loss or duplication.
REQ-026 flush_i at cycle 10 of DIV -> es_valid_o never asserts, es_allowin_o = 1 next cycle; rst at cycle 5 of DIV -> same.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: opcodes, ALU code mapping and divider state shared by the execute stage.
package ex_stage_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_NOR, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MUL, OP_MULU, OP_MULH, OP_MULHU,
    OP_DIV, OP_DIVU, OP_MOD, OP_MODU
  } aluop_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  function automatic logic is_alu_op(logic [4:0] op);
    return !op[4];
  endfunction
  function automatic logic is_div_op(logic [4:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_MOD, OP_MODU};
  endfunction
  // ALU opcodes occupy the low half of the enum, so the ALU code is the low nibble
  function automatic logic [3:0] alu_code(logic [4:0] op);
    return is_alu_op(op) ? op[3:0] : 4'd0;
  endfunction
endpackage

// File: rtl/ex_stage_div.sv
// iter_divider: radix-2 restoring divider, one quotient bit per cycle on magnitudes,
// signs restored on the way out; abort returns to IDLE from any state.
module iter_divider
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);
  div_state_e state_q;
  logic [5:0] cnt_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic qneg_q, rneg_q, a_neg, b_neg;
  logic [DATA_W:0] shifted;
  logic [DATA_W+1:0] trial;
  always_comb begin
    a_neg = signed_i && dividend_i[DATA_W-1];
    b_neg = signed_i && divisor_i[DATA_W-1];
    shifted = {rem_q, quo_q[DATA_W-1]};
    trial = {1'b0, shifted} - {2'b0, dvs_q};
    busy_o = state_q == DIV_BUSY;
    done_o = state_q == DIV_DONE;
    quotient_o = qneg_q ? -quo_q : quo_q;
    remainder_o = rneg_q ? -rem_q : rem_q;
  end
  // A zero divisor keeps the quotient positive so the all-ones pattern survives
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (abort_i) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
    end else case (state_q)
      DIV_IDLE: if (start_i) begin
        state_q <= DIV_BUSY;
        cnt_q <= 6'd31;
        rem_q <= '0;
        quo_q <= a_neg ? -dividend_i : dividend_i;
        dvs_q <= b_neg ? -divisor_i : divisor_i;
        qneg_q <= (a_neg ^ b_neg) && |divisor_i;
        rneg_q <= a_neg;
      end
      DIV_BUSY: begin
        rem_q <= trial[DATA_W+1] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], !trial[DATA_W+1]};
        if (cnt_q == 6'd0) state_q <= DIV_DONE;
        else cnt_q <= cnt_q - 6'd1;
      end
      default: ;
    endcase
endmodule

// File: rtl/ex_stage.sv
// ex_stage: single-entry execute pipeline stage; ALU ops pass straight through,
// divide/modulo ops run in the iterative divider before handing off.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ds_valid_i,
  output logic              es_allowin_o,
  input  logic [4:0]        ds_aluop_i,
  input  logic [DATA_W-1:0] ds_x_i,
  input  logic [DATA_W-1:0] ds_y_i,
  input  logic [4:0]        ds_dest_i,
  input  logic              ds_we_i,
  output logic [3:0]        alu_aluop_o,
  output logic [DATA_W-1:0] alu_x_o,
  output logic [DATA_W-1:0] alu_y_o,
  input  logic [DATA_W-1:0] alu_rl_i,
  input  logic [DATA_W-1:0] alu_rh_i,
  input  logic              ms_allowin_i,
  output logic              es_valid_o,
  output logic [DATA_W-1:0] es_result_o,
  output logic [4:0]        es_dest_o,
  output logic              es_we_o
);
  import ex_stage_pkg::*;
  logic es_valid_q, we_q;
  logic [4:0] aluop_q, dest_q;
  logic [DATA_W-1:0] x_q, y_q, quo, rem;
  logic es_ready_go, load, handoff, div_start, div_busy, div_done, div_signed, is_div;
  always_comb begin
    is_div = is_div_op(aluop_q);
    es_ready_go = is_div ? div_done : 1'b1;
    es_allowin_o = !es_valid_q || (es_ready_go && ms_allowin_i);
    es_valid_o = es_valid_q && es_ready_go && !flush_i;
    load = ds_valid_i && es_allowin_o && !flush_i;
    handoff = es_valid_o && ms_allowin_i;
    div_signed = aluop_q == OP_DIV || aluop_q == OP_MOD;
    div_start = es_valid_q && is_div && !div_busy && !div_done;
    alu_aluop_o = alu_code(aluop_q);
    alu_x_o = x_q;
    alu_y_o = y_q;
    es_result_o = !es_valid_q ? '0
                : is_alu_op(aluop_q) ? ((aluop_q == OP_MULH || aluop_q == OP_MULHU) ? alu_rh_i : alu_rl_i)
                : is_div ? ((aluop_q == OP_DIV || aluop_q == OP_DIVU) ? quo : rem)
                : '0;
    es_dest_o = dest_q;
    es_we_o = we_q && es_valid_o;
  end
  // Load wins over hand-off so a replacing instruction leaves no bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      es_valid_q <= 1'b0;
      aluop_q <= '0;
      x_q <= '0;
      y_q <= '0;
      dest_q <= '0;
      we_q <= 1'b0;
    end else if (flush_i) es_valid_q <= 1'b0;
    else if (load) begin
      es_valid_q <= 1'b1;
      aluop_q <= ds_aluop_i;
      x_q <= ds_x_i;
      y_q <= ds_y_i;
      dest_q <= ds_dest_i;
      we_q <= ds_we_i;
    end else if (handoff) es_valid_q <= 1'b0;
  iter_divider u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .signed_i   (div_signed),
    .dividend_i (x_q),
    .divisor_i  (y_q),
    .abort_i    (flush_i || handoff),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (quo),
    .remainder_o(rem)
  );
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven and randomized checks of ex_stage against an arithmetic model,
// with a behavioural ALU attached to the ALU ports.
module tb_ex_stage;
  import ex_stage_pkg::*;
  logic clk = 1'b0;
  logic rst, flush_i, ds_valid_i, es_allowin_o, ds_we_i, ms_allowin_i, es_valid_o, es_we_o;
  logic [4:0] ds_aluop_i, ds_dest_i, es_dest_o;
  logic [3:0] alu_aluop_o;
  logic [31:0] ds_x_i, ds_y_i, alu_x_o, alu_y_o, alu_rl_i, alu_rh_i, es_result_o, alu_p_hi;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ex_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .ds_valid_i(ds_valid_i), .es_allowin_o(es_allowin_o),
    .ds_aluop_i(ds_aluop_i), .ds_x_i(ds_x_i), .ds_y_i(ds_y_i), .ds_dest_i(ds_dest_i), .ds_we_i(ds_we_i),
    .alu_aluop_o(alu_aluop_o), .alu_x_o(alu_x_o), .alu_y_o(alu_y_o), .alu_rl_i(alu_rl_i), .alu_rh_i(alu_rh_i),
    .ms_allowin_i(ms_allowin_i), .es_valid_o(es_valid_o), .es_result_o(es_result_o),
    .es_dest_o(es_dest_o), .es_we_o(es_we_o)
  );
  function automatic logic [63:0] mul64(logic [4:0] op, logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == OP_MUL || op == OP_MULH) return 64'(sx * sy);
    return {32'b0, x} * {32'b0, y};
  endfunction
  function automatic logic [31:0] ref_low(logic [4:0] op, logic [31:0] x, logic [31:0] y);
    logic [63:0] p;
    p = mul64(op, x, y);
    case (op)
      OP_ADD: return x + y;
      OP_SUB: return x - y;
      OP_SLT: return {31'b0, $signed(x) < $signed(y)};
      OP_SLTU: return {31'b0, x < y};
      OP_AND: return x & y;
      OP_NOR: return ~(x | y);
      OP_OR: return x | y;
      OP_XOR: return x ^ y;
      OP_SLL: return x << y[4:0];
      OP_SRL: return x >> y[4:0];
      OP_SRA: return $unsigned($signed(x) >>> y[4:0]);
      OP_LUI: return {y[15:0], 16'h0};
      default: return p[31:0];
    endcase
  endfunction
  function automatic logic [31:0] ref_result(logic [4:0] op, logic [31:0] x, logic [31:0] y);
    logic [63:0] p;
    int sx, sy;
    sx = x;
    sy = y;
    p = mul64(op, x, y);
    if (op == OP_MULH || op == OP_MULHU) return p[63:32];
    if (!op[4]) return ref_low(op, x, y);
    if (op == OP_DIVU || op == OP_MODU) begin
      if (y == 0) return op == OP_DIVU ? 32'hFFFF_FFFF : x;
      if (op == OP_DIVU) return x / y;
      return x % y;
    end
    if (op == OP_DIV || op == OP_MOD) begin
      if (y == 0) return op == OP_DIV ? 32'hFFFF_FFFF : x;
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return op == OP_DIV ? 32'h8000_0000 : 32'h0;
      if (op == OP_DIV) return 32'(sx / sy);
      return 32'(sx % sy);
    end
    return 32'h0;
  endfunction
  always_comb begin
    alu_rl_i = ref_low({1'b0, alu_aluop_o}, alu_x_o, alu_y_o);
    {alu_p_hi, alu_rh_i} = {32'h0, mul64({1'b0, alu_aluop_o}, alu_x_o, alu_y_o)} >> 32;
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Enter and leave at 2 time units after a rising edge
  task automatic run_one(string nm, logic [4:0] op, logic [31:0] x, logic [31:0] y, logic [31:0] exp);
    int lat, lowc, w, exp_lat;
    logic [4:0] dst;
    logic we;
    dst = 5'($urandom);
    we = 1'($urandom);
    exp_lat = is_div_op(op) ? 33 : 0;
    w = 0;
    while (!es_allowin_o && w < 100) begin
      @(posedge clk); #2;
      w++;
    end
    if (w >= 100) chk({nm, "_allowin_timeout"}, {31'b0, es_allowin_o}, 32'd1);
    ds_valid_i = 1'b1; ds_aluop_i = op; ds_x_i = x; ds_y_i = y; ds_dest_i = dst; ds_we_i = we;
    @(posedge clk); #1;
    ds_valid_i = 1'b0;
    #1;
    lat = 0;
    lowc = 0;
    while (!es_valid_o && lat < 60) begin
      if (!es_allowin_o) lowc++;
      @(posedge clk); #2;
      lat++;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_allowin_low"}, lowc, exp_lat);
    chk({nm, "_result"}, es_result_o, exp);
    chk({nm, "_dest_we"}, {26'b0, es_dest_o, es_we_o}, {26'b0, dst, we});
    @(posedge clk); #2;
    chk({nm, "_drain"}, {31'b0, es_valid_o}, 32'd0);
  endtask
  typedef struct {
    string nm;
    logic [4:0] op;
    logic [31:0] x, y, exp;
  } vec_t;
  vec_t tbl[$];
  initial begin
    logic seen;
    rst = 1'b1; flush_i = 1'b0; ds_valid_i = 1'b0; ds_aluop_i = '0; ds_x_i = '0; ds_y_i = '0;
    ds_dest_i = '0; ds_we_i = 1'b0; ms_allowin_i = 1'b1;
    tbl.push_back('{"add", OP_ADD, 32'd5, 32'd7, 32'd12});
    tbl.push_back('{"sub", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE});
    tbl.push_back('{"slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1});
    tbl.push_back('{"sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0});
    tbl.push_back('{"sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000});
    tbl.push_back('{"mul", OP_MUL, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA});
    tbl.push_back('{"mulh", OP_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF});
    tbl.push_back('{"mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1});
    tbl.push_back('{"div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    tbl.push_back('{"mod_neg", OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    tbl.push_back('{"divu_zero", OP_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF});
    tbl.push_back('{"modu_zero", OP_MODU, 32'd10, 32'd0, 32'd10});
    tbl.push_back('{"div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    tbl.push_back('{"mod_ovf", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    tbl.push_back('{"div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
    tbl.push_back('{"mod_negdiv", OP_MOD, 32'd7, 32'hFFFF_FFFE, 32'd1});
    tbl.push_back('{"div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF});
    tbl.push_back('{"mod_zero", OP_MOD, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9});
    tbl.push_back('{"divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555});
    tbl.push_back('{"modu_bigdvs", OP_MODU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    tbl.push_back('{"divu_hi", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1});
    tbl.push_back('{"modu_hi", OP_MODU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE});
    tbl.push_back('{"unknown", 5'd25, 32'd9, 32'd9, 32'd0});
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", {28'b0, es_valid_o, es_we_o, es_allowin_o, |es_result_o}, 32'b0010);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_reset_state", {28'b0, es_valid_o, es_we_o, es_allowin_o, |es_result_o}, 32'b0010);
    foreach (tbl[i]) run_one(tbl[i].nm, tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].exp);
    // Back-to-back ADDs across a three-cycle downstream stall
    ms_allowin_i = 1'b0;
    ds_valid_i = 1'b1; ds_aluop_i = OP_ADD; ds_x_i = 32'd1; ds_y_i = 32'd2; ds_dest_i = 5'd3; ds_we_i = 1'b1;
    @(posedge clk); #1;
    ds_x_i = 32'd10; ds_y_i = 32'd20; ds_dest_i = 5'd4;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("stall_hold", {es_valid_o, es_allowin_o, es_dest_o, es_result_o[24:0]}, {1'b1, 1'b0, 5'd3, 25'd3});
      @(posedge clk); #2;
    end
    ms_allowin_i = 1'b1;
    #1;
    chk("stall_release", {es_valid_o, es_allowin_o, es_dest_o, es_result_o[24:0]}, {1'b1, 1'b1, 5'd3, 25'd3});
    @(posedge clk); #1;
    ds_valid_i = 1'b0;
    #1;
    chk("stall_next", {es_valid_o, es_allowin_o, es_dest_o, es_result_o[24:0]}, {1'b1, 1'b1, 5'd4, 25'd30});
    @(posedge clk); #2;
    chk("stall_drain", {31'b0, es_valid_o}, 32'd0);
    // Flush ten cycles into a divide, with a load attempt in the flush cycle
    ds_valid_i = 1'b1; ds_aluop_i = OP_DIV; ds_x_i = 32'd100; ds_y_i = 32'd7;
    @(posedge clk); #1;
    ds_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1; ds_valid_i = 1'b1; ds_aluop_i = OP_ADD; ds_x_i = 32'd1; ds_y_i = 32'd1;
    #1;
    chk("flush_cycle_valid", {31'b0, es_valid_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; ds_valid_i = 1'b0;
    #1;
    chk("flush_after", {30'b0, es_allowin_o, es_valid_o}, 32'b10);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
      seen |= es_valid_o;
    end
    chk("flush_no_result", {31'b0, seen}, 32'd0);
    run_one("div_after_flush", OP_DIV, 32'd100, 32'd7, 32'd14);
    // Asynchronous reset five cycles into a divide
    ds_valid_i = 1'b1; ds_aluop_i = OP_DIV; ds_x_i = 32'd100; ds_y_i = 32'd7;
    @(posedge clk); #1;
    ds_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_div", {28'b0, es_valid_o, es_we_o, es_allowin_o, |es_result_o}, 32'b0010);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
      seen |= es_valid_o;
    end
    chk("rst_no_result", {31'b0, seen}, 32'd0);
    run_one("modu_after_rst", OP_MODU, 32'd100, 32'd7, 32'd2);
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [4:0] op;
      logic [31:0] x, y;
      r = $urandom_range(0, 23);
      op = r < 20 ? 5'(r) : 5'($urandom_range(20, 31));
      case ($urandom_range(0, 3))
        0: x = 32'h8000_0000;
        1: x = 32'($urandom_range(0, 40)) - 32'd20;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(0, 40)) - 32'd20;
        default: y = $urandom;
      endcase
      run_one("random", op, x, y, ref_result(op, x, y));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
